audio_output_queue: RTL and testbench
=====================================

Name: audio_output_queue

Overview:
- Back end of the audio path; mirror of input_queue.
- Accepts time-domain frames from the inverse FFT over an AXI-Stream slave interface and buffers them in a two-bank ping-pong RAM.
- Replays samples at the audio sample rate as PWM on aud_pwm, and drives the amplifier enable aud_sd.
- Flags framing errors and playback underruns.

Parameters:
- DATA_WIDTH, 16: width of the real and imaginary parts of the IFFT output.
- FRAME_LEN, 1024: samples per frame; must be a power of 2.
- SAMPLE_DIV, 2083: clock cycles per output sample (100 MHz / 48 kHz); must be >= 2^PWM_BITS.
- PWM_BITS, 8: PWM duty resolution.

Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  2*DATA_WIDTH  IFFT output; imag in [2*DW-1:DW], real in [DW-1:0]. Only real is used.
- s_axis_tvalid  in  1  upstream data valid.
- s_axis_tready  out  1  block can accept a beat.
- s_axis_tlast  in  1  last beat of frame.
- aud_pwm  out  1  PWM audio output.
- aud_sd  out  1  amplifier enable; 1 = playing.
- frame_error  out  1  one-cycle pulse on a tlast/length mismatch.
- underrun  out  1  one-cycle pulse when a sample tick finds no full bank.

Behaviour:
- Reset: all outputs 0; both banks empty; wr_bank = rd_bank = 0; indices 0; read FSM IDLE; duty = midscale (2^(PWM_BITS-1)). s_tready = 1 on the first cycle after reset deasserts. Reset mid-operation discards all buffered data.
- Storage: mem[2][FRAME_LEN] of DATA_WIDTH bits, plus per-bank full flags full[1:0].

Write side:
- s_tready = ~full[wr_bank].
- On a handshake (tvalid & tready), store real into mem[wr_bank][wr_idx] and increment wr_idx.
- Last beat (wr_idx == FRAME_LEN-1): set full[wr_bank], toggle wr_bank, clear wr_idx. If tlast is also 0, pulse frame_error; the frame is still committed.
- Early tlast (wr_idx < FRAME_LEN-1): pulse frame_error, clear wr_idx, leave the bank empty. The partial frame is dropped.
- tvalid without tready: no state change. Upstream must hold its data.

Sample tick:
- tick_cnt counts 0..SAMPLE_DIV-1 and wraps. It is free-running from reset.
- tick is asserted when tick_cnt == SAMPLE_DIV-1.

Read FSM:
- IDLE: aud_sd = 0, duty = midscale. Go to PLAY on the first cycle full[rd_bank] == 1, and set aud_sd = 1 in that same transition.
- PLAY, tick with full[rd_bank] = 1:
  - Issue a registered read of mem[rd_bank][rd_idx] and increment rd_idx.
  - If rd_idx == FRAME_LEN-1: clear full[rd_bank], toggle rd_bank, clear rd_idx.
- PLAY, tick with full[rd_bank] = 0: pulse underrun, set duty_pending = midscale, stay in PLAY with aud_sd held at 1.
- PLAY has no exit except reset.

Duty conversion:
- duty_pending = real[DW-1:DW-PWM_BITS] with the MSB inverted (signed to offset binary).
- Examples: 0x7FFF gives 2^PWM_BITS-1; 0x8000 gives 0; 0x0000 gives midscale.
- No rounding; truncation only.

PWM:
- pwm_cnt is free-running over 0..2^PWM_BITS-1.
- aud_pwm = (pwm_cnt < duty), registered.
- duty loads duty_pending only when pwm_cnt wraps to 0, so pulses are glitch-free.

Latency:
- Tick at cycle t, RAM read at t+1, duty_pending valid at t+2, applied at the next pwm_cnt wrap.

Simultaneous events:
- A commit on one bank and a release on the other in the same cycle both take effect.
- The same bank can never be set and cleared in the same cycle: the writer only touches empty banks and the reader only releases full ones.
- A bank released in cycle n shows s_tready = 1 in cycle n+1.

Test Plan:
(Bench parameters: FRAME_LEN=8, SAMPLE_DIV=16, PWM_BITS=4, DATA_WIDTH=16.)
1. Hold reset 4 cycles, then release -> during reset all outputs 0; s_tready = 1 from the cycle after release; aud_sd = 0; aud_pwm = 0 until a frame arrives... then duty stays 8 with aud_sd = 0.
2. Send one 8-beat frame, real = 0x7FFF, tlast on beat 8 -> aud_sd = 1 the cycle after the commit; after the latency, aud_pwm is high 15 of every 16 cycles for 8 sample periods.
3. Send three back-to-back frames with tvalid held high -> s_tready drops after beat 16; it rises the cycle after bank 0 releases (8 ticks into playback); frame 3 is then accepted and played in order 1, 2, 3.
4. Send tlast on beat 3, then a valid 8-beat frame -> frame_error pulses for exactly 1 cycle on beat 3; only the second frame plays; no underrun.
5. Send one frame of real = 0x8000 (duty 0) and no further frames -> 8 samples with aud_pwm = 0; the 9th tick pulses underrun; duty becomes 8 (8/16 high); aud_sd stays 1; underrun repeats every 16 cycles.
6. Assert reset mid-playback with both banks full -> the next cycle shows aud_sd = 0, aud_pwm = 0, s_tready = 0; after release s_tready = 1, FSM IDLE, and there is no playback until a new frame is committed.

Source files
------------

// File: rtl/audio_output_queue.sv
// Audio output queue: buffers IFFT frames in a two-bank ping-pong RAM and
// replays the real part one sample per SAMPLE_DIV clocks as PWM on aud_pwm.
module audio_output_queue #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned SAMPLE_DIV = 2083,
  parameter int unsigned PWM_BITS   = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    aud_pwm,
  output logic                    aud_sd,
  output logic                    frame_error,
  output logic                    underrun
);

  localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
  localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);

  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [PWM_BITS-1:0] MIDSCALE  = PWM_BITS'(1) << (PWM_BITS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [2][FRAME_LEN];
  logic [DATA_WIDTH-1:0] rd_word_q;

  logic [0:0]          state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
  logic [1:0]          full_q, full_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic                tready_q, tready_d;
  logic                aud_sd_q, aud_sd_d;
  logic                frame_error_q, frame_error_d;
  logic                underrun_q, underrun_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_mid_q, rd_mid_d;
  logic [PWM_BITS-1:0] duty_pending_q, duty_pending_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                aud_pwm_q, aud_pwm_d;

  logic wr_hs;
  logic tick;
  logic rd_req;

  // Only the real half and the top PWM_BITS of each stored sample matter.
  logic unused_bits;
  assign unused_bits = ^{s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH],
                         rd_word_q[DATA_WIDTH-PWM_BITS-1:0]};

  // Next-state logic for the write side, read FSM and PWM.
  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    rd_bank_d      = rd_bank_q;
    wr_idx_d       = wr_idx_q;
    rd_idx_d       = rd_idx_q;
    full_d         = full_q;
    aud_sd_d       = aud_sd_q;
    frame_error_d  = 1'b0;
    underrun_d     = 1'b0;
    rd_en_d        = 1'b0;
    rd_mid_d       = 1'b0;
    duty_pending_d = duty_pending_q;
    rd_req         = 1'b0;

    wr_hs = s_axis_tvalid & tready_q;
    if (wr_hs) begin
      if (wr_idx_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
        frame_error_d     = ~s_axis_tlast;
      end else if (s_axis_tlast) begin
        wr_idx_d      = '0;
        frame_error_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = ST_PLAY;
          aud_sd_d = 1'b1;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          rd_en_d = 1'b1;
          if (full_q[rd_bank_q]) begin
            rd_req   = 1'b1;
            rd_idx_d = rd_idx_q + IDX_W'(1);
            if (rd_idx_q == LAST_IDX) begin
              full_d[rd_bank_q] = 1'b0;
              rd_bank_d         = ~rd_bank_q;
              rd_idx_d          = '0;
            end
          end else begin
            rd_mid_d   = 1'b1;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Underrun goes through the same stage as a RAM read so latency is uniform.
    if (rd_en_q) begin
      duty_pending_d = rd_mid_q ? MIDSCALE
                                : (rd_word_q[DATA_WIDTH-1 -: PWM_BITS] ^ MIDSCALE);
    end

    tready_d  = ~full_d[wr_bank_d];
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    duty_d    = (pwm_cnt_q == '1) ? duty_pending_q : duty_q;
    aud_pwm_d = (state_q == ST_PLAY) & (pwm_cnt_q < duty_q);
  end

  // Sample RAM: one write port, one registered read port; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_hs && !reset) begin
      mem_q[wr_bank_q][wr_idx_q] <= s_axis_tdata[DATA_WIDTH-1:0];
    end
    if (rd_req) begin
      rd_word_q <= mem_q[rd_bank_q][rd_idx_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      wr_idx_q       <= '0;
      rd_idx_q       <= '0;
      full_q         <= '0;
      tick_cnt_q     <= '0;
      tready_q       <= 1'b0;
      aud_sd_q       <= 1'b0;
      frame_error_q  <= 1'b0;
      underrun_q     <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_mid_q       <= 1'b0;
      duty_pending_q <= MIDSCALE;
      duty_q         <= MIDSCALE;
      pwm_cnt_q      <= '0;
      aud_pwm_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_bank_q      <= wr_bank_d;
      rd_bank_q      <= rd_bank_d;
      wr_idx_q       <= wr_idx_d;
      rd_idx_q       <= rd_idx_d;
      full_q         <= full_d;
      tick_cnt_q     <= tick_cnt_d;
      tready_q       <= tready_d;
      aud_sd_q       <= aud_sd_d;
      frame_error_q  <= frame_error_d;
      underrun_q     <= underrun_d;
      rd_en_q        <= rd_en_d;
      rd_mid_q       <= rd_mid_d;
      duty_pending_q <= duty_pending_d;
      duty_q         <= duty_d;
      pwm_cnt_q      <= pwm_cnt_d;
      aud_pwm_q      <= aud_pwm_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign aud_sd        = aud_sd_q;
  assign aud_pwm       = aud_pwm_q;
  assign frame_error   = frame_error_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_audio_output_queue.sv
// Bench for audio_output_queue: directed scenarios plus random frames, checked
// every cycle against a frame-queue model of playback timing.
module tb_audio_output_queue;

  localparam int DW  = 16;
  localparam int FL  = 8;
  localparam int SD  = 16;
  localparam int PB  = 4;
  localparam int PP  = 1 << PB;
  localparam int MID = 1 << (PB - 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2*DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic          aud_pwm;
  logic          aud_sd;
  logic          frame_error;
  logic          underrun;

  audio_output_queue #(
    .DATA_WIDTH(DW), .FRAME_LEN(FL), .SAMPLE_DIV(SD), .PWM_BITS(PB)
  ) dut (
    .clock(clock), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .aud_pwm(aud_pwm), .aud_sd(aud_sd),
    .frame_error(frame_error), .underrun(underrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  beat_t         src_q[$];
  logic [DW-1:0] cur[$];
  logic [DW-1:0] sq[$];
  int            dp[int];
  int            c, held, wr_idx_m, rd_cnt, valid_pct;
  bit            exp_tready, exp_sd, prev_sd, exp_ferr, exp_und;
  int            passed = 0;
  int            total  = 0;
  int            fails  = 0;

  function automatic int conv(input logic [DW-1:0] r);
    return (int'($signed(r)) + 32768) >> (DW - PB);
  endfunction

  function automatic int duty_of(input int p);
    return dp.exists(p) ? dp[p] : MID;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, c, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    src_q.delete(); cur.delete(); sq.delete(); dp.delete();
    c = 0; held = 0; wr_idx_m = 0; rd_cnt = 0;
    exp_tready = 1'b0; exp_sd = 1'b0; prev_sd = 1'b0;
    exp_ferr = 1'b0; exp_und = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(posedge clock); #1;
    repeat (n) begin
      @(negedge clock);
      check("rst_tready", s_axis_tready, 1'b0);
      check("rst_sd", aud_sd, 1'b0);
      check("rst_pwm", aud_pwm, 1'b0);
      check("rst_ferr", frame_error, 1'b0);
      check("rst_und", underrun, 1'b0);
      @(posedge clock); #1;
    end
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive, check outputs mid-cycle, advance the model.
  task automatic step();
    bit v, hs, last, nferr, nund;
    int nheld, y;
    bit exp_pwm;
    logic [DW-1:0] d, s;
    v = (src_q.size() > 0) && ($urandom_range(99) < valid_pct);
    d = v ? src_q[0].d : '0;
    last = v ? src_q[0].last : 1'b0;
    s_axis_tvalid = v;
    s_axis_tdata  = {16'($urandom), d};
    s_axis_tlast  = last;
    @(negedge clock);
    y = c - 1;
    exp_pwm = (c > 0) && prev_sd && ((y % PP) < duty_of(y / PP));
    check("tready", s_axis_tready, exp_tready);
    check("aud_sd", aud_sd, exp_sd);
    check("frame_error", frame_error, exp_ferr);
    check("underrun", underrun, exp_und);
    check("aud_pwm", aud_pwm, exp_pwm);

    hs = v && s_axis_tready;
    nheld = held; nferr = 1'b0; nund = 1'b0;
    if (hs) begin
      void'(src_q.pop_front());
      cur.push_back(d);
      if (wr_idx_m == FL - 1) begin
        nferr = !last;
        foreach (cur[i]) sq.push_back(cur[i]);
        cur.delete();
        wr_idx_m = 0;
        nheld++;
      end else if (last) begin
        nferr = 1'b1;
        cur.delete();
        wr_idx_m = 0;
      end else begin
        wr_idx_m++;
      end
    end
    // A sample chosen at this tick takes effect in the PWM period after the
    // one in which it becomes pending (two cycles later).
    if ((c % SD) == SD - 1 && exp_sd) begin
      if (held > 0) begin
        s = sq.pop_front();
        dp[(c + 2) / PP + 1] = conv(s);
        rd_cnt++;
        if (rd_cnt == FL) begin
          rd_cnt = 0;
          nheld--;
        end
      end else begin
        nund = 1'b1;
        dp[(c + 2) / PP + 1] = MID;
      end
    end
    prev_sd    = exp_sd;
    exp_sd     = exp_sd || (held > 0);
    held       = nheld;
    exp_tready = (held < 2);
    exp_ferr   = nferr;
    exp_und    = nund;
    c++;
    @(posedge clock); #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (src_q.size() > 0 && k < bound) begin
      step();
      k++;
    end
    check_int("drain_remaining", src_q.size(), 0);
  endtask

  // kind 0: constant val, kind 1: random data.
  task automatic push_frame(input int n, input bit last_on_final, input int kind,
                            input logic [DW-1:0] val);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.d    = (kind == 0) ? val : DW'($urandom);
      b.last = last_on_final && (i == n - 1);
      src_q.push_back(b);
    end
  endtask

  initial begin
    valid_pct = 100;

    // Reset and idle: no playback, tready rises one cycle after release.
    do_reset(4);
    run(40);

    // Full-scale frame.
    do_reset(2);
    push_frame(FL, 1'b1, 0, 16'h7FFF);
    drain(100);
    run(FL * SD + 48);

    // Three back-to-back frames exercise backpressure and bank release.
    do_reset(2);
    push_frame(FL, 1'b1, 1, '0);
    push_frame(FL, 1'b1, 1, '0);
    push_frame(FL, 1'b1, 1, '0);
    drain(1000);
    run(3 * FL * SD + 40);

    // Early tlast drops a partial frame; the following frame plays.
    do_reset(2);
    push_frame(3, 1'b1, 0, 16'h1234);
    push_frame(FL, 1'b1, 1, '0);
    drain(100);
    run(FL * SD + 20);

    // Missing tlast on the final beat still commits the frame.
    do_reset(2);
    push_frame(FL, 1'b0, 1, '0);
    drain(100);
    run(FL * SD + 20);

    // Minimum-scale frame followed by repeated underruns.
    do_reset(2);
    push_frame(FL, 1'b1, 0, 16'h8000);
    drain(100);
    run(FL * SD + 5 * SD);

    // Reset mid-playback with both banks full discards everything.
    do_reset(2);
    push_frame(FL, 1'b1, 0, 16'h4000);
    push_frame(FL, 1'b1, 0, 16'hC000);
    drain(200);
    run(3 * SD);
    do_reset(2);
    run(4 * SD);

    // Random frames, random valid gaps, occasional framing errors.
    do_reset(2);
    for (int f = 0; f < 14; f++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 10)      push_frame(int'($urandom_range(1, FL - 1)), 1'b1, 1, '0);
      else if (r < 18) push_frame(FL, 1'b0, 1, '0);
      else             push_frame(FL, 1'b1, 1, '0);
    end
    valid_pct = 60;
    drain(5000);
    run(3 * FL * SD);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
